alu_ctrl_encode_stage: RTL and testbench

//  Decode-side producer of ALU control: turns a fetched LC-3b instruction into the
//  lc3b_aluop code, immediate B operand and register indices the ALU and regfile

---
 rtl/alu_ctrl_encode_stage_if.sv | 48 ++++
 rtl/alu_ctrl_encode_stage.sv | 179 +++++++++++++++++
 tb/tb_alu_ctrl_encode_stage.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_ctrl_encode_stage_if.sv
// ============================================================================
// Module      : alu_ctrl_encode_stage_if
// Description : Fetch-side and execute-side handshake bundle for the
//               ALU-control encode stage. The fetch side presents instruction
//               and PC. The execute side receives the decoded ALU control.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface alu_ctrl_encode_stage_if #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
);
  // fetch -> stage
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_instr;
  logic [WIDTH-1:0] in_pc;

  // stage -> execute
  logic             out_valid;
  logic             out_ready;
  logic [OPW-1:0]   out_aluop;
  logic [WIDTH-1:0] out_b_imm;
  logic             out_b_is_imm;
  logic [2:0]       out_sr1;
  logic [2:0]       out_sr2;
  logic [2:0]       out_dr;
  logic             out_ld_reg;
  logic [WIDTH-1:0] out_pc;

  // environment side: drives fetch data and execute back-pressure
  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_aluop, out_b_imm, out_b_is_imm,
           out_sr1, out_sr2, out_dr, out_ld_reg, out_pc
  );

  // stage side
  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_aluop, out_b_imm, out_b_is_imm,
           out_sr1, out_sr2, out_dr, out_ld_reg, out_pc
  );
endinterface

`default_nettype wire

// File: rtl/alu_ctrl_encode_stage.sv
// ============================================================================
// Module      : alu_ctrl_encode_stage
// Description : Decodes LC-3b instructions into ALU op, B-immediate and
//               register indices. Registered stage with a main output slot
//               and a skid slot, so in_ready comes straight from a flop.
//               Flush squashes all held entries and any same-cycle input.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module alu_ctrl_encode_stage #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  wire logic               clk,
  input  wire logic               reset_n,
  input  wire logic               flush,
  alu_ctrl_encode_stage_if.slave  bus
);

  localparam logic [3:0] c_OP_ADD  = 4'b0001;
  localparam logic [3:0] c_OP_AND  = 4'b0101;
  localparam logic [3:0] c_OP_NOT  = 4'b1001;
  localparam logic [3:0] c_OP_SHF  = 4'b1101;
  localparam logic [3:0] c_OP_LEA  = 4'b1110;
  localparam logic [3:0] c_OP_TRAP = 4'b1111;

  localparam logic [OPW-1:0] c_ALU_ADD  = OPW'(0);
  localparam logic [OPW-1:0] c_ALU_AND  = OPW'(1);
  localparam logic [OPW-1:0] c_ALU_NOT  = OPW'(2);
  localparam logic [OPW-1:0] c_ALU_PASS = OPW'(3);
  localparam logic [OPW-1:0] c_ALU_SLL  = OPW'(4);
  localparam logic [OPW-1:0] c_ALU_SRL  = OPW'(5);
  localparam logic [OPW-1:0] c_ALU_SRA  = OPW'(6);
  localparam logic [OPW-1:0] c_ALU_TRAP = OPW'(7);

  typedef struct packed {
    logic [OPW-1:0]   aluop;
    logic [WIDTH-1:0] b_imm;
    logic             b_is_imm;
    logic [2:0]       sr1;
    logic [2:0]       sr2;
    logic [2:0]       dr;
    logic             ld_reg;
    logic [WIDTH-1:0] pc;
  } entry_t;

  entry_t r_main;
  logic   r_main_valid;
  entry_t r_skid;
  logic   r_skid_valid;
  logic   r_in_ready;

  entry_t w_dec;
  entry_t w_main_nxt;
  logic   w_main_valid_nxt;
  entry_t w_skid_nxt;
  logic   w_skid_valid_nxt;
  logic   w_in_fire;
  logic   w_out_fire;
  logic   w_main_free;
  logic [3:0] w_op;

  assign w_op        = bus.in_instr[15:12];
  // in_ready is already low whenever the skid slot is occupied, so an input
  // transfer can never coincide with a full skid slot.
  assign w_in_fire   = bus.in_valid & r_in_ready;
  assign w_out_fire  = r_main_valid & bus.out_ready;
  assign w_main_free = ~r_main_valid | w_out_fire;

  // Decode the instruction currently presented by fetch.
  always_comb begin
    w_dec          = '0;
    w_dec.aluop    = c_ALU_PASS;
    w_dec.sr1      = bus.in_instr[8:6];
    w_dec.sr2      = bus.in_instr[2:0];
    w_dec.dr       = bus.in_instr[11:9];
    w_dec.pc       = bus.in_pc;
    unique case (w_op)
      c_OP_ADD, c_OP_AND: begin
        w_dec.aluop  = (w_op == c_OP_ADD) ? c_ALU_ADD : c_ALU_AND;
        w_dec.ld_reg = 1'b1;
        if (bus.in_instr[5]) begin
          w_dec.b_is_imm = 1'b1;
          w_dec.b_imm    = {{(WIDTH-5){bus.in_instr[4]}}, bus.in_instr[4:0]};
        end
      end
      c_OP_NOT: begin
        w_dec.aluop  = c_ALU_NOT;
        w_dec.ld_reg = 1'b1;
      end
      c_OP_SHF: begin
        w_dec.ld_reg   = 1'b1;
        w_dec.b_is_imm = 1'b1;
        w_dec.b_imm    = {{(WIDTH-4){1'b0}}, bus.in_instr[3:0]};
        unique case (bus.in_instr[5:4])
          2'b01:   w_dec.aluop = c_ALU_SRL;
          2'b11:   w_dec.aluop = c_ALU_SRA;
          default: w_dec.aluop = c_ALU_SLL;
        endcase
      end
      c_OP_LEA: begin
        w_dec.aluop    = c_ALU_ADD;
        w_dec.ld_reg   = 1'b1;
        w_dec.b_is_imm = 1'b1;
        w_dec.b_imm    = {{(WIDTH-10){bus.in_instr[8]}}, bus.in_instr[8:0], 1'b0};
      end
      c_OP_TRAP: begin
        w_dec.aluop    = c_ALU_TRAP;
        w_dec.ld_reg   = 1'b1;
        w_dec.b_is_imm = 1'b1;
        w_dec.b_imm    = {{(WIDTH-9){1'b0}}, bus.in_instr[7:0], 1'b0};
        w_dec.dr       = 3'd7;
      end
      default: begin
        w_dec.aluop = c_ALU_PASS;
      end
    endcase
  end

  // Slot steering: the skid entry refills main first, preserving FIFO order.
  // New input goes to main when it is free and to skid otherwise.
  always_comb begin
    w_main_nxt       = r_main;
    w_main_valid_nxt = r_main_valid;
    w_skid_nxt       = r_skid;
    w_skid_valid_nxt = r_skid_valid;
    if (flush) begin
      w_main_valid_nxt = 1'b0;
      w_skid_valid_nxt = 1'b0;
    end else if (w_main_free) begin
      if (r_skid_valid) begin
        w_main_nxt       = r_skid;
        w_main_valid_nxt = 1'b1;
        w_skid_valid_nxt = 1'b0;
      end else if (w_in_fire) begin
        w_main_nxt       = w_dec;
        w_main_valid_nxt = 1'b1;
      end else begin
        w_main_valid_nxt = 1'b0;
      end
    end else if (w_in_fire) begin
      w_skid_nxt       = w_dec;
      w_skid_valid_nxt = 1'b1;
    end
  end

  // Slot registers. in_ready is registered as "skid slot will be empty".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_main       <= '0;
      r_main_valid <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
      r_in_ready   <= 1'b1;
    end else begin
      r_main       <= w_main_nxt;
      r_main_valid <= w_main_valid_nxt;
      r_skid       <= w_skid_nxt;
      r_skid_valid <= w_skid_valid_nxt;
      r_in_ready   <= ~w_skid_valid_nxt;
    end
  end

  assign bus.in_ready     = r_in_ready;
  assign bus.out_valid    = r_main_valid;
  assign bus.out_aluop    = r_main.aluop;
  assign bus.out_b_imm    = r_main.b_imm;
  assign bus.out_b_is_imm = r_main.b_is_imm;
  assign bus.out_sr1      = r_main.sr1;
  assign bus.out_sr2      = r_main.sr2;
  assign bus.out_dr       = r_main.dr;
  assign bus.out_ld_reg   = r_main.ld_reg;
  assign bus.out_pc       = r_main.pc;

endmodule

`default_nettype wire

// File: tb/tb_alu_ctrl_encode_stage.sv
// ============================================================================
// Module      : tb_alu_ctrl_encode_stage
// Description : Self-checking bench for alu_ctrl_encode_stage. Uses directed
//               steps followed by a randomized stream. A queue-based model
//               tracks the held entries and decodes them from instruction
//               fields.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_alu_ctrl_encode_stage;
  localparam int WIDTH = 16;
  localparam int OPW   = 3;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  logic flush   = 1'b0;

  alu_ctrl_encode_stage_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

  alu_ctrl_encode_stage #(.WIDTH(WIDTH), .OPW(OPW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Entries held by the stage, oldest first: {instr, pc}.
  logic [31:0] q[$];

  typedef struct {
    int          aluop;
    logic [15:0] b_imm;
    logic        b_is_imm;
    int          sr1;
    int          sr2;
    int          dr;
    logic        ld_reg;
    logic        chk_sr2;
  } exp_t;

  // Expected decode, written from the instruction-set field rules.
  function automatic exp_t model(input logic [15:0] instr);
    exp_t e;
    int   op;
    int   v;
    op         = int'(instr[15:12]);
    e.aluop    = 3;
    e.b_imm    = 16'h0;
    e.b_is_imm = 1'b0;
    e.sr1      = int'(instr[8:6]);
    e.sr2      = int'(instr[2:0]);
    e.dr       = int'(instr[11:9]);
    e.ld_reg   = 1'b0;
    e.chk_sr2  = 1'b0;
    case (op)
      1, 5: begin
        e.aluop  = (op == 1) ? 0 : 1;
        e.ld_reg = 1'b1;
        if (instr[5]) begin
          v = int'(instr[4:0]);
          if (v >= 16) v = v - 32;
          e.b_imm    = v[15:0];
          e.b_is_imm = 1'b1;
        end else begin
          e.chk_sr2 = 1'b1;
        end
      end
      9: begin
        e.aluop  = 2;
        e.ld_reg = 1'b1;
      end
      13: begin
        case (int'(instr[5:4]))
          1:       e.aluop = 5;
          3:       e.aluop = 6;
          default: e.aluop = 4;
        endcase
        v          = int'(instr[3:0]);
        e.b_imm    = v[15:0];
        e.b_is_imm = 1'b1;
        e.ld_reg   = 1'b1;
      end
      14: begin
        v = int'(instr[8:0]);
        if (v >= 256) v = v - 512;
        v          = v * 2;
        e.aluop    = 0;
        e.b_imm    = v[15:0];
        e.b_is_imm = 1'b1;
        e.ld_reg   = 1'b1;
      end
      15: begin
        v          = int'(instr[7:0]) * 2;
        e.aluop    = 7;
        e.b_imm    = v[15:0];
        e.b_is_imm = 1'b1;
        e.dr       = 7;
        e.ld_reg   = 1'b1;
      end
      default: ;
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Compare every visible output against the model's head-of-queue entry.
  task automatic check_outputs();
    exp_t        e;
    logic [31:0] h;
    chk("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
    chk("in_ready",  32'(bus.in_ready),  32'(q.size() < 2));
    if (q.size() > 0) begin
      h = q[0];
      e = model(h[31:16]);
      chk("aluop",    32'(bus.out_aluop),    32'(e.aluop));
      chk("b_is_imm", 32'(bus.out_b_is_imm), 32'(e.b_is_imm));
      chk("ld_reg",   32'(bus.out_ld_reg),   32'(e.ld_reg));
      chk("pc",       32'(bus.out_pc),       32'(h[15:0]));
      if (e.b_is_imm) chk("b_imm", 32'(bus.out_b_imm), 32'(e.b_imm));
      if (e.ld_reg) begin
        chk("dr",  32'(bus.out_dr),  32'(e.dr));
        chk("sr1", 32'(bus.out_sr1), 32'(e.sr1));
      end
      if (e.chk_sr2) chk("sr2", 32'(bus.out_sr2), 32'(e.sr2));
    end
  endtask

  // One clock: drive at negedge, update the model at posedge, check at the next negedge.
  task automatic step(input logic v, input logic [15:0] instr, input logic [15:0] pc,
                      input logic ordy, input logic fl, output logic acc);
    logic out_acc;
    bus.in_valid  = v;
    bus.in_instr  = instr;
    bus.in_pc     = pc;
    bus.out_ready = ordy;
    flush         = fl;
    acc     = v && (q.size() < 2) && !fl;
    out_acc = (q.size() > 0) && ordy && !fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
    end else begin
      if (out_acc) void'(q.pop_front());
      if (acc) q.push_back({instr, pc});
    end
    @(negedge clk);
    check_outputs();
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_out_valid"}, 32'(bus.out_valid),    32'd0);
    chk({tag, "_in_ready"},  32'(bus.in_ready),     32'd1);
    chk({tag, "_aluop"},     32'(bus.out_aluop),    32'd0);
    chk({tag, "_b_imm"},     32'(bus.out_b_imm),    32'd0);
    chk({tag, "_b_is_imm"},  32'(bus.out_b_is_imm), 32'd0);
    chk({tag, "_regs"},      32'({bus.out_sr1, bus.out_sr2, bus.out_dr}), 32'd0);
    chk({tag, "_ld_reg"},    32'(bus.out_ld_reg),   32'd0);
    chk({tag, "_pc"},        32'(bus.out_pc),       32'd0);
  endtask

  initial begin
    logic        acc;
    logic [15:0] t3[3];
    int          idx;
    bus.in_valid  = 1'b0;
    bus.in_instr  = 16'h0;
    bus.in_pc     = 16'h0;
    bus.out_ready = 1'b0;

    // reset state
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset");
    reset_n = 1'b1;

    // T1: ADD R1,R2,#-3
    step(1'b1, 16'h12BD, 16'h3000, 1'b1, 1'b0, acc);
    chk("t1_aluop", 32'(bus.out_aluop), 32'd0);
    chk("t1_b_imm", 32'(bus.out_b_imm), 32'h0000FFFD);
    chk("t1_dr",    32'(bus.out_dr),    32'd1);
    chk("t1_sr1",   32'(bus.out_sr1),   32'd2);

    // T2: shifts and TRAP
    step(1'b1, 16'hD735, 16'h3002, 1'b1, 1'b0, acc);
    chk("t2_sra_aluop", 32'(bus.out_aluop), 32'd6);
    chk("t2_sra_b_imm", 32'(bus.out_b_imm), 32'h5);
    chk("t2_sra_dr",    32'(bus.out_dr),    32'd3);
    chk("t2_sra_sr1",   32'(bus.out_sr1),   32'd4);
    step(1'b1, 16'hD6F5, 16'h3004, 1'b1, 1'b0, acc);
    step(1'b1, 16'hF025, 16'h3006, 1'b1, 1'b0, acc);
    chk("t2_trap_aluop", 32'(bus.out_aluop), 32'd7);
    chk("t2_trap_b_imm", 32'(bus.out_b_imm), 32'h4A);
    chk("t2_trap_dr",    32'(bus.out_dr),    32'd7);
    step(1'b1, 16'hE1FF, 16'h3008, 1'b1, 1'b0, acc);  // LEA, negative offset
    step(1'b1, 16'h1442, 16'h300A, 1'b1, 1'b0, acc);  // ADD register form
    step(1'b1, 16'h0E05, 16'h300C, 1'b1, 1'b0, acc);  // BR: pass
    step(1'b0, 16'h0000, 16'h0000, 1'b1, 1'b0, acc);

    // T3: back-pressure fills the skid slot, then drains in order
    t3[0] = 16'h1000; t3[1] = 16'h5000; t3[2] = 16'h9000;
    idx = 0;
    for (int c = 0; c < 9; c++) begin
      step(idx < 3, (idx < 3) ? t3[idx] : 16'h0, 16'h4000 + 16'(idx), c >= 3, 1'b0, acc);
      if (acc) idx++;
    end
    chk("t3_all_accepted", 32'(idx), 32'd3);

    // T4: streaming, one per cycle
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 16'h1020 + 16'(i), 16'h5000 + 16'(i), 1'b1, 1'b0, acc);
      chk("t4_accept", 32'(acc), 32'd1);
    end
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, acc);

    // T5: flush with two held and one offered
    step(1'b1, 16'h1111, 16'h6000, 1'b0, 1'b0, acc);
    step(1'b1, 16'h5222, 16'h6002, 1'b0, 1'b0, acc);
    step(1'b1, 16'h9333, 16'h6004, 1'b0, 1'b1, acc);
    chk("t5_out_valid", 32'(bus.out_valid), 32'd0);
    chk("t5_in_ready",  32'(bus.in_ready),  32'd1);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, acc);
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, acc);

    // T6: asynchronous reset with entries held
    step(1'b1, 16'h1234, 16'h7000, 1'b0, 1'b0, acc);
    step(1'b1, 16'h5678, 16'h7002, 1'b0, 1'b0, acc);
    bus.in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    check_reset_state("t6");
    q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, acc);

    // randomized stream with back-pressure and occasional flush
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 4) != 0, 16'($urandom), 16'($urandom),
           ($urandom % 3) != 0, ($urandom % 30) == 0, acc);
    end
    for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 16'h0, 1'b1, 1'b0, acc);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

`default_nettype wire
